// File: rtl/matmul_feeder_if.sv
// rtl/matmul_feeder_if.sv - core operand/result stream and memory port bundle for matmul_feeder
interface matmul_feeder_if #(
    parameter int W  = 32,
    parameter int AW = 10
);
    // matmul core side
    logic          mm_start;
    logic [63:0]   mm_dims_a;
    logic [63:0]   mm_dims_b;
    logic [W-1:0]  mm_in_a;
    logic [W-1:0]  mm_in_b;
    logic [2:0]    mm_state;
    logic [W-1:0]  mm_out_c;

    // operand memories (synchronous read, one cycle latency) and result memory
    logic [AW-1:0] mem_a_addr;
    logic [W-1:0]  mem_a_rdata;
    logic [AW-1:0] mem_b_addr;
    logic [W-1:0]  mem_b_rdata;
    logic [AW-1:0] mem_c_addr;
    logic [W-1:0]  mem_c_wdata;
    logic          mem_c_we;

    modport master (
        output mm_start, mm_dims_a, mm_dims_b, mm_in_a, mm_in_b,
        input  mm_state, mm_out_c,
        output mem_a_addr, mem_b_addr,
        input  mem_a_rdata, mem_b_rdata,
        output mem_c_addr, mem_c_wdata, mem_c_we
    );

    modport slave (
        input  mm_start, mm_dims_a, mm_dims_b, mm_in_a, mm_in_b,
        output mm_state, mm_out_c,
        input  mem_a_addr, mem_b_addr,
        output mem_a_rdata, mem_b_rdata,
        input  mem_c_addr, mem_c_wdata, mem_c_we
    );
endinterface

// File: rtl/matmul_feeder.sv
// rtl/matmul_feeder.sv - streams A/B operands from memory into a matmul core and drains C back
module matmul_feeder #(
    parameter int W  = 32,
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             go,
    input  logic [31:0]      rows_a,
    input  logic [31:0]      cols_a,
    input  logic [31:0]      rows_b,
    input  logic [31:0]      cols_b,
    input  logic [AW-1:0]    base_a,
    input  logic [AW-1:0]    base_b,
    input  logic [AW-1:0]    base_c,
    output logic             busy,
    output logic             done,
    output logic             err,
    matmul_feeder_if.master  bus
);

    // core state encodings as reported on mm_state
    localparam logic [2:0] MM_IDLE  = 3'd0;
    localparam logic [2:0] MM_WRITE = 3'd3;
    localparam logic [2:0] MM_ERROR = 3'd4;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [63:0]   ONE64    = 64'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t        state;

    // job parameters captured when the job is accepted
    logic [63:0]   dims_a;
    logic [63:0]   dims_b;
    logic [63:0]   a_els;
    logic [63:0]   b_els;
    logic [63:0]   c_els;
    logic [63:0]   feed_len;
    logic [AW-1:0] c_base;

    // progress counters
    logic [63:0]   feed_cnt;
    logic [63:0]   a_idx;
    logic [63:0]   b_idx;
    logic [63:0]   drain_cnt;

    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [AW-1:0] c_addr;
    logic          start_r;
    logic          done_r;

    // element counts of the incoming request, full 64-bit products
    logic [63:0]   a_els_in;
    logic [63:0]   b_els_in;
    logic [63:0]   c_els_in;

    assign a_els_in = {32'd0, rows_a} * {32'd0, cols_a};
    assign b_els_in = {32'd0, rows_b} * {32'd0, cols_b};
    assign c_els_in = {32'd0, rows_a} * {32'd0, cols_b};

    // read pointers advance until they sit on the last element, then hold it
    logic a_step;
    logic b_step;

    assign a_step = (a_idx + ONE64) < a_els;
    assign b_step = (b_idx + ONE64) < b_els;

    // core health: on the very first feed cycle the core may still be IDLE,
    // so only ERROR aborts there; afterwards IDLE also means the core gave up
    logic core_dead;
    logic feed_abort;
    logic wait_abort;

    assign core_dead  = (bus.mm_state == MM_IDLE) || (bus.mm_state == MM_ERROR);
    assign feed_abort = (state == S_FEED) &&
                        ((feed_cnt == 64'd0) ? (bus.mm_state == MM_ERROR) : core_dead);
    assign wait_abort = (state == S_WAIT) && core_dead;

    // job sequencer: accept, start the core, feed operands, wait, drain results
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            dims_a    <= '0;
            dims_b    <= '0;
            a_els     <= '0;
            b_els     <= '0;
            c_els     <= '0;
            feed_len  <= '0;
            c_base    <= '0;
            feed_cnt  <= '0;
            a_idx     <= '0;
            b_idx     <= '0;
            drain_cnt <= '0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_addr    <= '0;
            start_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        dims_a   <= {rows_a, cols_a};
                        dims_b   <= {rows_b, cols_b};
                        a_els    <= a_els_in;
                        b_els    <= b_els_in;
                        c_els    <= c_els_in;
                        feed_len <= (a_els_in > b_els_in) ? a_els_in : b_els_in;
                        c_base   <= base_c;
                        a_addr   <= base_a;
                        b_addr   <= base_b;
                        a_idx    <= '0;
                        b_idx    <= '0;
                        start_r  <= 1'b1;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    // element 0 is already addressed; issue element 1 for feed cycle 1
                    feed_cnt <= '0;
                    if (a_step) begin
                        a_idx  <= a_idx + ONE64;
                        a_addr <= a_addr + ADDR_ONE;
                    end
                    if (b_step) begin
                        b_idx  <= b_idx + ONE64;
                        b_addr <= b_addr + ADDR_ONE;
                    end
                    state <= (feed_len == 64'd0) ? S_WAIT : S_FEED;
                end

                S_FEED: begin
                    if (feed_abort) begin
                        state <= S_IDLE;
                    end else begin
                        if (a_step) begin
                            a_idx  <= a_idx + ONE64;
                            a_addr <= a_addr + ADDR_ONE;
                        end
                        if (b_step) begin
                            b_idx  <= b_idx + ONE64;
                            b_addr <= b_addr + ADDR_ONE;
                        end
                        if (feed_cnt == feed_len - ONE64) begin
                            state <= S_WAIT;
                        end else begin
                            feed_cnt <= feed_cnt + ONE64;
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_abort) begin
                        state <= S_IDLE;
                    end else if (bus.mm_state == MM_WRITE) begin
                        c_addr    <= c_base;
                        drain_cnt <= '0;
                        if (c_els == 64'd0) begin
                            done_r <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // the core's state is no longer watched: a started drain always completes
                    if (drain_cnt == c_els - ONE64) begin
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + ONE64;
                        c_addr    <= c_addr + ADDR_ONE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_r;
    assign err  = feed_abort || wait_abort;

    assign bus.mm_start  = start_r;
    assign bus.mm_dims_a = dims_a;
    assign bus.mm_dims_b = dims_b;

    // operands pass straight from the read ports; the held last address keeps the tail value
    assign bus.mm_in_a = (state == S_FEED) ? bus.mem_a_rdata : '0;
    assign bus.mm_in_b = (state == S_FEED) ? bus.mem_b_rdata : '0;

    assign bus.mem_a_addr  = a_addr;
    assign bus.mem_b_addr  = b_addr;
    assign bus.mem_c_addr  = c_addr;
    assign bus.mem_c_we    = (state == S_DRAIN);
    assign bus.mem_c_wdata = (state == S_DRAIN) ? bus.mm_out_c : '0;

endmodule

// File: tb/tb_matmul_feeder.sv
// tb/tb_matmul_feeder.sv - self-checking bench for matmul_feeder with a behavioural matmul core
module tb_matmul_feeder;

    logic        clk;
    logic        rstn;
    logic        go;
    logic [31:0] rows_a, cols_a, rows_b, cols_b;
    logic [9:0]  base_a, base_b, base_c;
    logic        busy, done, err;

    matmul_feeder_if #(.W(32), .AW(10)) bus ();

    matmul_feeder #(.W(32), .AW(10)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .go     (go),
        .rows_a (rows_a),
        .cols_a (cols_a),
        .rows_b (rows_b),
        .cols_b (cols_b),
        .base_a (base_a),
        .base_b (base_b),
        .base_c (base_c),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // operand memories
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    always @(posedge clk) begin
        bus.mem_a_rdata <= mem_a[bus.mem_a_addr];
        bus.mem_b_rdata <= mem_b[bus.mem_b_addr];
    end

    // behavioural core: READ for max(els) cycles, CALCULATE calc_len cycles,
    // one WRITE announce cycle, then one result per cycle
    int          core_mode;   // 0 normal, 1 ERROR on start, 2 IDLE after reading
    int          calc_len;
    logic [2:0]  core_state;
    int          rd_cnt, calc_cnt, wr_cnt;
    int          ca [64];
    int          cb [64];
    int          cres [64];
    int          c_ra, c_ca, c_rb, c_cb, c_r, c_c;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_state <= 3'd0;
            rd_cnt     <= 0;
            calc_cnt   <= 0;
            wr_cnt     <= 0;
        end else begin
            case (core_state)
                3'd0: if (bus.mm_start) begin
                    c_ra = int'(bus.mm_dims_a[63:32]);
                    c_ca = int'(bus.mm_dims_a[31:0]);
                    c_rb = int'(bus.mm_dims_b[63:32]);
                    c_cb = int'(bus.mm_dims_b[31:0]);
                    c_r  = (c_ra * c_ca > c_rb * c_cb) ? c_ra * c_ca : c_rb * c_cb;
                    c_c  = c_ra * c_cb;
                    rd_cnt     <= 0;
                    core_state <= (core_mode == 1) ? 3'd4 : 3'd1;
                end
                3'd1: begin
                    ca[rd_cnt] = int'(bus.mm_in_a);
                    cb[rd_cnt] = int'(bus.mm_in_b);
                    if (rd_cnt == c_r - 1) begin
                        for (int i = 0; i < c_ra; i++)
                            for (int j = 0; j < c_cb; j++) begin
                                cres[i*c_cb+j] = 0;
                                for (int k = 0; k < c_ca; k++)
                                    cres[i*c_cb+j] += ca[i*c_ca+k] * cb[k*c_cb+j];
                            end
                        if (core_mode == 2) core_state <= 3'd0;
                        else if (calc_len == 0) begin
                            core_state <= 3'd3;
                            wr_cnt     <= 0;
                        end else begin
                            core_state <= 3'd2;
                            calc_cnt   <= 0;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 1;
                    end
                end
                3'd2: if (calc_cnt == calc_len - 1) begin
                    core_state <= 3'd3;
                    wr_cnt     <= 0;
                end else begin
                    calc_cnt <= calc_cnt + 1;
                end
                3'd3: if (wr_cnt == c_c) core_state <= 3'd0;
                      else wr_cnt <= wr_cnt + 1;
                default: core_state <= 3'd0;
            endcase
        end
    end

    assign bus.mm_state = core_state;
    assign bus.mm_out_c = (core_state == 3'd3 && wr_cnt > 0) ? 32'(cres[(wr_cnt > 0) ? wr_cnt - 1 : 0]) : 32'd0;

    // scoreboard: expected writes queued with the stimulus, observed writes captured here
    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q [$];
    wr_t obs_q [$];
    int  done_cnt, err_cnt, both_cnt;

    always @(negedge clk) begin
        if (bus.mem_c_we === 1'b1) obs_q.push_back('{bus.mem_c_addr, bus.mem_c_wdata});
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
    end

    int n_pass, n_total;

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
    endtask

    task automatic load_2x2(input int ba, input int bb);
        for (int i = 0; i < 4; i++) begin
            mem_a[ba + i] = 32'(i + 1);
            mem_b[bb + i] = 32'(i + 5);
        end
    endtask

    task automatic push_2x2(input int bc);
        exp_q.push_back('{10'(bc),     32'd19});
        exp_q.push_back('{10'(bc + 1), 32'd22});
        exp_q.push_back('{10'(bc + 2), 32'd43});
        exp_q.push_back('{10'(bc + 3), 32'd50});
    endtask

    // drives go for the accepting edge; returns at the negedge of job cycle 1
    task automatic start_job(input int ra, input int cla, input int rb, input int clb,
                             input int ba, input int bb, input int bc, input bit hold);
        @(negedge clk);
        rows_a = 32'(ra); cols_a = 32'(cla);
        rows_b = 32'(rb); cols_b = 32'(clb);
        base_a = 10'(ba); base_b = 10'(bb); base_c = 10'(bc);
        go = 1'b1;
        @(negedge clk);
        if (!hold) go = 1'b0;
    endtask

    task automatic wait_done(input int start_n, output int n_done);
        int n;
        n = start_n;
        n_done = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                n_done = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; go = 1'b0;
        rows_a = '0; cols_a = '0; rows_b = '0; cols_b = '0;
        base_a = '0; base_b = '0; base_c = '0;
        core_mode = 0; calc_len = 2;
        clear_mem();
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, err, bus.mm_start, bus.mem_c_we} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, bus.mm_start, bus.mem_c_we});
        else n_pass++;
        n_total++;
        if ({bus.mem_a_addr, bus.mem_b_addr, bus.mem_c_addr, bus.mm_dims_a} !== '0)
            $display("FAIL reset_addr_dims got=%h exp=0", {bus.mem_a_addr, bus.mem_b_addr, bus.mem_c_addr, bus.mm_dims_a});
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_basic_2x2();
        int n;
        wr_t e, o;
        clear_mem(); load_2x2(4, 8); push_2x2(20);
        core_mode = 0; calc_len = 2; done_cnt = 0; err_cnt = 0;
        start_job(2, 2, 2, 2, 4, 8, 20, 1'b0);
        n_total++;
        if ({busy, bus.mm_start} !== 2'b11) $display("FAIL basic_start got=%b exp=11", {busy, bus.mm_start});
        else n_pass++;
        n_total++;
        if (bus.mm_dims_a !== {32'd2, 32'd2}) $display("FAIL basic_dims_a got=%h exp=%h", bus.mm_dims_a, {32'd2, 32'd2});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.mm_start, bus.mm_in_a, bus.mm_in_b} !== {1'b0, 32'd1, 32'd5})
            $display("FAIL basic_feed0 got=%0d/%0d/%0d exp=0/1/5", bus.mm_start, bus.mm_in_a, bus.mm_in_b);
        else n_pass++;
        wait_done(2, n);
        n_total++;
        if (n !== 13) $display("FAIL basic_done_cycle got=%0d exp=13", n);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL basic_pulses got=%0d/%0d exp=1/0", done_cnt, err_cnt);
        else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL basic_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.addr !== e.addr || o.data !== e.data)
                $display("FAIL basic_wr got=%0d@%0d exp=%0d@%0d", o.data, o.addr, e.data, e.addr);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_core_error();
        clear_mem(); load_2x2(0, 0);
        core_mode = 1; calc_len = 2; done_cnt = 0; err_cnt = 0; obs_q.delete();
        start_job(2, 3, 4, 2, 0, 0, 50, 1'b0);
        n_total++;
        if (err !== 1'b0) $display("FAIL error_early got=%b exp=0", err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({err, busy} !== 2'b11) $display("FAIL error_pulse got=%b exp=11", {err, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({err, busy} !== 2'b00) $display("FAIL error_after got=%b exp=00", {err, busy});
        else n_pass++;
        repeat (10) @(negedge clk);
        n_total++;
        if ({obs_q.size(), done_cnt, err_cnt} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL error_effects got=%0d/%0d/%0d exp=0/0/1", obs_q.size(), done_cnt, err_cnt);
        else n_pass++;
        core_mode = 0;
    endtask

    task automatic test_uneven_feed();
        int n;
        wr_t e, o;
        clear_mem();
        for (int i = 0; i < 6; i++) mem_a[100 + i] = 32'(i + 1);
        for (int i = 0; i < 3; i++) mem_b[200 + i] = 32'(i + 1);
        exp_q.push_back('{10'd300, 32'd14});
        exp_q.push_back('{10'd301, 32'd32});
        core_mode = 0; calc_len = 0; obs_q.delete();
        start_job(2, 3, 3, 1, 100, 200, 300, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++;
            if (bus.mm_in_a !== 32'(i + 1) || bus.mm_in_b !== 32'((i < 3) ? i + 1 : 3))
                $display("FAIL uneven_feed%0d got=%0d/%0d exp=%0d/%0d", i, bus.mm_in_a, bus.mm_in_b, i + 1, (i < 3) ? i + 1 : 3);
            else n_pass++;
        end
        n_total++;
        if ({bus.mem_a_addr, bus.mem_b_addr} !== {10'd105, 10'd202})
            $display("FAIL uneven_addr_hold got=%0d/%0d exp=105/202", bus.mem_a_addr, bus.mem_b_addr);
        else n_pass++;
        wait_done(7, n);
        n_total++;
        if (n !== 11) $display("FAIL uneven_done_cycle got=%0d exp=11", n);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL uneven_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.addr !== e.addr || o.data !== e.data)
                $display("FAIL uneven_wr got=%0d@%0d exp=%0d@%0d", o.data, o.addr, e.data, e.addr);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_job();
        int n;
        wr_t e, o;
        clear_mem(); load_2x2(10, 30);
        core_mode = 0; calc_len = 2; done_cnt = 0; err_cnt = 0; obs_q.delete();
        start_job(2, 2, 2, 2, 10, 30, 60, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_total++;
        if ({busy, done, err, bus.mm_start, bus.mem_c_we, bus.mm_in_a, bus.mm_in_b, bus.mem_c_wdata} !== '0)
            $display("FAIL rstmid_outputs got=%h exp=0", {busy, done, err, bus.mm_start, bus.mem_c_we, bus.mm_in_a, bus.mm_in_b, bus.mem_c_wdata});
        else n_pass++;
        n_total++;
        if ({bus.mem_a_addr, bus.mem_b_addr, bus.mem_c_addr, bus.mm_dims_a, bus.mm_dims_b} !== '0)
            $display("FAIL rstmid_addr_dims got=%h exp=0", {bus.mem_a_addr, bus.mem_b_addr, bus.mem_c_addr, bus.mm_dims_a, bus.mm_dims_b});
        else n_pass++;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({done_cnt, err_cnt, obs_q.size()} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL rstmid_no_pulse got=%0d/%0d/%0d exp=0/0/0", done_cnt, err_cnt, obs_q.size());
        else n_pass++;
        push_2x2(60);
        start_job(2, 2, 2, 2, 10, 30, 60, 1'b0);
        wait_done(1, n);
        n_total++;
        if (n !== 13) $display("FAIL rstmid_done_cycle got=%0d exp=13", n);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.addr !== e.addr || o.data !== e.data)
                $display("FAIL rstmid_wr got=%0d@%0d exp=%0d@%0d", o.data, o.addr, e.data, e.addr);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        wr_t e, o;
        clear_mem(); load_2x2(4, 8);
        push_2x2(20); push_2x2(40);
        core_mode = 0; calc_len = 2; done_cnt = 0; err_cnt = 0; obs_q.delete();
        start_job(2, 2, 2, 2, 4, 8, 20, 1'b1);
        base_c = 10'd40;
        wait_done(1, n);
        n_total++;
        if (n !== 13) $display("FAIL b2b_done1_cycle got=%0d exp=13", n);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, bus.mm_start} !== 2'b11) $display("FAIL b2b_restart got=%b exp=11", {busy, bus.mm_start});
        else n_pass++;
        go = 1'b0;
        wait_done(1, n);
        n_total++;
        if (n !== 13) $display("FAIL b2b_done2_cycle got=%0d exp=13", n);
        else n_pass++;
        repeat (20) @(negedge clk);
        n_total++;
        if ({busy, done_cnt} !== {1'b0, 32'd2}) $display("FAIL b2b_job_count got=%0d/%0d exp=0/2", busy, done_cnt);
        else n_pass++;
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.addr !== e.addr || o.data !== e.data)
                $display("FAIL b2b_wr got=%0d@%0d exp=%0d@%0d", o.data, o.addr, e.data, e.addr);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_wait_idle();
        int first_err;
        clear_mem(); load_2x2(0, 0);
        core_mode = 2; calc_len = 2; done_cnt = 0; err_cnt = 0; obs_q.delete();
        first_err = -1;
        start_job(2, 2, 2, 2, 0, 0, 70, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (err === 1'b1 && first_err < 0) first_err = c;
        end
        n_total++;
        if (first_err !== 6) $display("FAIL waitidle_err_cycle got=%0d exp=6", first_err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, err} !== 2'b00) $display("FAIL waitidle_after got=%b exp=00", {busy, err});
        else n_pass++;
        repeat (5) @(negedge clk);
        n_total++;
        if ({obs_q.size(), done_cnt, err_cnt} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL waitidle_effects got=%0d/%0d/%0d exp=0/0/1", obs_q.size(), done_cnt, err_cnt);
        else n_pass++;
        core_mode = 0;
    endtask

    task automatic test_addr_wrap();
        int n;
        wr_t e, o;
        clear_mem();
        mem_a[1022] = 32'd2; mem_a[1023] = 32'd0; mem_a[0] = 32'd1; mem_a[1] = 32'd3;
        mem_b[1023] = 32'd1; mem_b[0] = 32'd1; mem_b[1] = 32'd0; mem_b[2] = 32'd2;
        exp_q.push_back('{10'd1022, 32'd2});
        exp_q.push_back('{10'd1023, 32'd2});
        exp_q.push_back('{10'd0,    32'd1});
        exp_q.push_back('{10'd1,    32'd7});
        core_mode = 0; calc_len = 2; obs_q.delete();
        start_job(2, 2, 2, 2, 1022, 1023, 1022, 1'b0);
        wait_done(1, n);
        n_total++;
        if (n !== 13) $display("FAIL wrap_done_cycle got=%0d exp=13", n);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL wrap_wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o.addr !== e.addr || o.data !== e.data)
                $display("FAIL wrap_wr got=%0d@%0d exp=%0d@%0d", o.data, o.addr, e.data, e.addr);
            else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
        test_reset();
        test_basic_2x2();
        test_core_error();
        test_uneven_feed();
        test_reset_mid_job();
        test_back_to_back();
        test_wait_idle();
        test_addr_wrap();
        n_total++;
        if (both_cnt !== 0) $display("FAIL done_err_overlap got=%0d exp=0", both_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
